uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares a single `uart_controller` transmitter between `NUM_REQ` byte-stream requesters. It arbitrates round-robin at message granularity and locks the grant until the requester's last byte, so messages never interleave. It can prepend a channel-ID header byte to each message. A watchdog releases the grant if a locked requester stalls. It sits between the requester datapaths and the UART's `tx_data_valid`/`tx_data_ready`/`tx_data` port.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `HDR_EN`, 1: 1 = send a header byte `8'h80 | grant_id` before each message; 0 = no header.
- `TIMEOUT`, 1024: idle cycles tolerated mid-message before abort; must be ≥ 1.

Clock and reset: reset reset, synchronous, active-high; clock clk.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `req_valid`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- `req_last`  in  NUM_REQ  marks the final byte of a message; qualified by `req_valid`
- `req_ready`  out  NUM_REQ  per-requester byte accepted
- `uart_tx_valid`  out  1  to UART `tx_data_valid`
- `uart_tx_data`  out  8  to UART `tx_data`
- `uart_tx_ready`  in  1  from UART `tx_data_ready`
- `grant_id`  out  4  index of the current owner; valid while `busy`
- `busy`  out  1  a message is in progress (state ≠ IDLE)
- `abort`  out  1  one-cycle pulse when the watchdog terminates a message
- `abort_id`  out  4  owner index of the aborted message; holds until the next abort

## Operation
- FSM states: IDLE, HDR, DATA.
- **IDLE**
  - If any `req_valid` is high, pick the winner: first set bit scanning from `(last_grant+1) mod NUM_REQ` upward, wrapping.
  - Register the winner into `grant_id` and `last_grant`.
  - Next state is HDR if `HDR_EN`, else DATA.
  - If no `req_valid` is high, stay in IDLE.
- **HDR**
  - `uart_tx_valid`=1, `uart_tx_data`=`8'h80|grant_id`. All `req_ready`=0.
  - On `uart_tx_ready`, go to DATA.
- **DATA**
  - Combinational passthrough: `uart_tx_valid`=`req_valid[grant_id]`, `uart_tx_data`=byte `grant_id` of `req_data`, `req_ready[grant_id]`=`uart_tx_ready`.
  - All other `req_ready` bits are 0.
  - A handshake (valid & ready) with `req_last[grant_id]`=1 returns the FSM to IDLE.
- **Watchdog (DATA only)**
  - Counter `wd` clears on entry to DATA and on every handshake.
  - Otherwise `wd` increments on each cycle where `req_valid[grant_id]`=0.
  - When `wd` reaches `TIMEOUT`: the `abort` pulse is driven for 1 cycle, `abort_id`←`grant_id`, and the FSM returns to IDLE.
  - `wd` does not count while valid is high and the UART backpressures; UART stalls never abort.
  - `wd` width is `$clog2(TIMEOUT+1)`.
- **Outputs in IDLE:** `uart_tx_valid`=0, `req_ready`=0, `uart_tx_data`=0.
- **No interleave:** requests from non-owners are ignored until the FSM returns to IDLE.
- The block does not inspect UART bit timing; the UART `tx_data_ready` alone gates every transfer.

## Timing
- **Reset values:** state=IDLE, `last_grant`=NUM_REQ-1 (channel 0 wins first), `grant_id`=0, `busy`=0, `abort`=0, `abort_id`=0, `wd`=0, `uart_tx_valid`=0, `req_ready`=0.
- **Arbitration latency:** `req_valid` high in IDLE at cycle t → HDR (or DATA) at t+1. The header is offered to the UART at t+1.
- **Header handshake:** at cycle h; first data byte offered at h+1.
- **Zero-latency data path:** `req_ready`, `uart_tx_valid` and `uart_tx_data` in DATA are combinational; there are no bubbles inside a message beyond UART backpressure.
- **Inter-message gap:** the last-byte handshake at cycle l → IDLE at l+1 → next grant at l+2. The minimum gap is 1 IDLE cycle.
- **Stability:** a requester must hold `req_data`/`req_last` stable while `req_valid`=1 and `req_ready`=0. The header is held stable by construction.
- **Abort timing:** `req_valid[grant_id]` low from cycle s onward → `abort` pulses at cycle s+TIMEOUT-1, IDLE at s+TIMEOUT.
- **Simultaneous handshake and timeout:** the handshake wins; `wd` clears and no abort occurs.
- **Reset mid-message:** synchronous return to IDLE next cycle with all reset values. No abort pulse. The UART may still be serialising an accepted byte; that is not the scheduler's concern.
- **`req_last` on the first data byte:** a 1-byte message is legal.

## Test plan
- **Single message:** HDR_EN=1; req 2 sends bytes 0x11,0x22,0x33 (last on 0x33); UART ready always. Expected: UART sees 0x82,0x11,0x22,0x33, then `busy`=0.
- **Round-robin:** `req_valid`=4'b1111 from reset, each sending 1-byte messages. Expected grant order 0,1,2,3,0; headers 0x80,0x81,0x82,0x83,0x80.
- **Lock:** req 1 sends a 4-byte message; req 0 raises valid during byte 2. Expected: req 0 gets no `req_ready` until req 1's last byte, then is granted 2 cycles later.
- **Backpressure:** UART ready low for 50 cycles mid-message while valid is held. Expected: `uart_tx_data` stable, no abort, transfer completes.
- **Watchdog:** TIMEOUT=16; req 3 drops valid after its first byte. Expected: `abort`=1 for one cycle 15 cycles later, `abort_id`=3, IDLE on the next cycle.
- **Reset mid-message:** assert reset during DATA. Expected next cycle: `busy`=0, `uart_tx_valid`=0, `req_ready`=0, `abort`=0; after release, channel 0 has priority.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester byte streams and UART tx port bundle
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_valid;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_ready;

  modport master (
    output req_valid, req_data, req_last, uart_tx_ready,
    input  req_ready, uart_tx_valid, uart_tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_ready,
    output req_ready, uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - message-locked round-robin sharing of one UART transmitter
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int HDR_EN  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_scheduler_if.slave bus,
  output logic [3:0]         grant_id_o,
  output logic               busy_o,
  output logic               abort_o,
  output logic [3:0]         abort_id_o
);
  localparam int GW   = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]   LAST_RST = GW'(NUM_REQ - 1);
  localparam logic [GW:0]     N_W      = (GW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [3:0]      abort_id_q, abort_id_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic [7:0]      req_byte [NUM_REQ];
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            sel_hs;
  logic            wd_expire;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW:0]     rr_start;
  logic [NUM_REQ-1:0] rr_rot;
  logic [GW:0]     rr_pos;
  logic [GW:0]     rr_sum;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  assign sel_valid = bus.req_valid[grant_q];
  assign sel_last  = bus.req_last[grant_q];
  assign sel_data  = req_byte[grant_q];
  assign sel_hs    = sel_valid & bus.uart_tx_ready;
  // Only an absent byte ages the watchdog, so UART backpressure can never abort.
  assign wd_expire = !sel_valid && (wd_q == WD_LAST);

  // Rotate so the slot after last_grant sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rr_start  = {1'b0, last_q} + 1'b1;
    rr_rot    = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_start);
    win_found = |bus.req_valid;
    rr_pos    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rr_rot[k]) rr_pos = (GW + 1)'(k);
    end
    rr_sum = rr_start + rr_pos;
    if (rr_sum >= N_W) rr_sum = rr_sum - N_W;
    win_idx = GW'(rr_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      abort_id_q <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      abort_id_q <= abort_id_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    abort_id_d = abort_id_q;
    wd_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          last_d  = win_idx;
          state_d = (HDR_EN != 0) ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        if (bus.uart_tx_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sel_hs) begin
          if (sel_last) state_d = ST_IDLE;
        end else if (wd_expire) begin
          state_d    = ST_IDLE;
          abort_id_d = 4'(grant_q);
        end else if (!sel_valid) begin
          wd_d = wd_q + 1'b1;
        end else begin
          wd_d = wd_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.uart_tx_valid = 1'b0;
    bus.uart_tx_data  = 8'h00;
    bus.req_ready     = '0;
    abort_o           = 1'b0;
    case (state_q)
      ST_HDR: begin
        bus.uart_tx_valid = 1'b1;
        bus.uart_tx_data  = 8'h80 | 8'(grant_q);
      end
      ST_DATA: begin
        bus.uart_tx_valid      = sel_valid;
        bus.uart_tx_data       = sel_data;
        bus.req_ready[grant_q] = bus.uart_tx_ready;
        abort_o                = wd_expire;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign grant_id_o = 4'(grant_q);
  assign abort_id_o = abort_id_q;
endmodule
